// File: rtl/cnn_conv_sequencer.sv
// Control FSM for one ROWS x COLS tile convolved with a K x K filter (stride 1, no padding).
// Issues buffer reads, MAC clear/enable strobes and hands finished pixels out via valid/ready.
module cnn_conv_sequencer #(
    parameter int ROWS    = 8,
    parameter int COLS    = 32,
    parameter int K       = 3,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 1,
    localparam int OUT_ROWS = ROWS - K + 1,
    localparam int OUT_COLS = COLS - K + 1,
    localparam int IAW      = $clog2(ROWS * COLS),
    localparam int FAW      = $clog2(K * K),
    localparam int OAW      = $clog2(OUT_ROWS * OUT_COLS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           img_rd_en,
    output logic [IAW-1:0] img_addr,
    output logic           flt_rd_en,
    output logic [FAW-1:0] flt_addr,
    output logic           mac_en,
    output logic           mac_clr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OAW-1:0] out_addr
);

    localparam int RW    = $clog2(OUT_ROWS + 1);
    localparam int CW    = $clog2(OUT_COLS + 1);
    localparam int KW    = $clog2(K + 1);
    localparam int DRAIN = RD_LAT + MAC_LAT;
    localparam int DW    = $clog2(DRAIN);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN_S, WRITE, DONE_S} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [KW-1:0] kr;
    logic [KW-1:0] kc;
    logic [DW-1:0] drn_cnt;

    logic rd_en;
    logic rd_first;
    logic tap_last;
    logic pix_last;

    // Read strobe delay line feeding the MAC, one entry per read-latency cycle
    logic rd_vld_p   [RD_LAT];
    logic rd_first_p [RD_LAT];

    assign rd_en    = (state == ACCUM);
    assign rd_first = rd_en && (kr == '0) && (kc == '0);
    assign tap_last = (kr == KW'(K - 1)) && (kc == KW'(K - 1));
    assign pix_last = (r == RW'(OUT_ROWS - 1)) && (c == CW'(OUT_COLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (tap_last) state_nxt = DRAIN_S;
            DRAIN_S: if (drn_cnt == '0) state_nxt = WRITE;
            WRITE:   if (out_ready) state_nxt = pix_last ? DONE_S : ACCUM;
            DONE_S:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r       <= '0;
            c       <= '0;
            kr      <= '0;
            kc      <= '0;
            drn_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r  <= '0;
                        c  <= '0;
                        kr <= '0;
                        kc <= '0;
                    end
                end
                ACCUM: begin
                    if (kc == KW'(K - 1)) begin
                        kc <= '0;
                        if (kr == KW'(K - 1)) begin
                            kr      <= '0;
                            drn_cnt <= DW'(DRAIN - 1);
                        end else begin
                            kr <= kr + 1'b1;
                        end
                    end else begin
                        kc <= kc + 1'b1;
                    end
                end
                DRAIN_S: begin
                    if (drn_cnt != '0) drn_cnt <= drn_cnt - 1'b1;
                end
                WRITE: begin
                    if (out_ready && !pix_last) begin
                        if (c == CW'(OUT_COLS - 1)) begin
                            c <= '0;
                            r <= r + 1'b1;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                end
                DONE_S: begin
                    r <= '0;
                    c <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_vld_p[i]   <= 1'b0;
                rd_first_p[i] <= 1'b0;
            end
        end else begin
            rd_vld_p[0]   <= rd_en;
            rd_first_p[0] <= rd_first;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_p[i]   <= rd_vld_p[i-1];
                rd_first_p[i] <= rd_first_p[i-1];
            end
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE_S);
        img_rd_en = rd_en;
        flt_rd_en = rd_en;
        img_addr  = '0;
        flt_addr  = '0;
        out_valid = (state == WRITE);
        out_addr  = '0;
        mac_en    = rd_vld_p[RD_LAT-1];
        mac_clr   = rd_first_p[RD_LAT-1];
        if (rd_en) begin
            img_addr = IAW'((32'(r) + 32'(kr)) * 32'(COLS) + 32'(c) + 32'(kc));
            flt_addr = FAW'(32'(kr) * 32'(K) + 32'(kc));
        end
        if (state == WRITE) begin
            out_addr = OAW'(32'(r) * 32'(OUT_COLS) + 32'(c));
        end
    end

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// Directed bench for cnn_conv_sequencer: default 8x32/K=3 instance plus a 4x4, RD_LAT=2, MAC_LAT=3 instance.
module tb_cnn_conv_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, out_ready;
    logic       busy, done, img_rd_en, flt_rd_en, mac_en, mac_clr, out_valid;
    logic [7:0] img_addr, out_addr;
    logic [3:0] flt_addr;

    logic       s_start, s_ready;
    logic       s_busy, s_done, s_img_rd_en, s_flt_rd_en, s_mac_en, s_mac_clr, s_out_valid;
    logic [3:0] s_img_addr, s_flt_addr;
    logic [1:0] s_out_addr;

    int errors = 0;
    int checks = 0;

    cnn_conv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .img_rd_en(img_rd_en), .img_addr(img_addr), .flt_rd_en(flt_rd_en), .flt_addr(flt_addr),
        .mac_en(mac_en), .mac_clr(mac_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr)
    );

    cnn_conv_sequencer #(.ROWS(4), .COLS(4), .K(3), .RD_LAT(2), .MAC_LAT(3)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .img_rd_en(s_img_rd_en), .img_addr(s_img_addr), .flt_rd_en(s_flt_rd_en), .flt_addr(s_flt_addr),
        .mac_en(s_mac_en), .mac_clr(s_mac_clr), .out_valid(s_out_valid), .out_ready(s_ready),
        .out_addr(s_out_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_tile(input int bp_pix, input int exp_done, input bit poke, input string tag);
        int cyc, hs, hold, first_a, last_a;
        bit fin;
        cyc = 0; hs = 0; hold = 0; first_a = -1; last_a = -1; fin = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc < exp_done + 100) begin
            if (poke) start = (cyc == 5) || done;
            if (img_rd_en && hs == 179) begin
                if (first_a < 0) first_a = int'(img_addr);
                last_a = int'(img_addr);
            end
            if (hold >= 1 && hold <= 5) begin
                chk({tag, "_hold_valid"}, out_valid, 1);
                chk({tag, "_hold_addr"}, out_addr, bp_pix);
                chk({tag, "_hold_rd"}, img_rd_en, 0);
                chk({tag, "_hold_mac"}, mac_en, 0);
                hold++;
                out_ready = (hold == 6);
            end else if (hold == 0 && bp_pix >= 0 && out_valid && int'(out_addr) == bp_pix) begin
                hold = 1;
                out_ready = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk({tag, "_out_addr"}, out_addr, hs);
                hs++;
            end
            if (done) begin
                chk({tag, "_done_cycle"}, cyc, exp_done);
                chk({tag, "_pixels"}, hs, 180);
                chk({tag, "_busy_in_done"}, busy, 1);
                fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!fin) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_done_single"}, done, 0);
        @(negedge clk);
        chk({tag, "_not_queued"}, busy, 0);
        chk({tag, "_last_first_addr"}, first_a, 189);
        chk({tag, "_last_last_addr"}, last_a, 255);
    endtask

    initial begin
        int img_tbl[9];
        int base_tbl[4];
        int cyc, hs, pix;
        bit fin;
        img_tbl  = '{0, 1, 2, 32, 33, 34, 64, 65, 66};
        base_tbl = '{0, 1, 4, 5};
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; s_start = 1'b0; s_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_ctrl", {busy, done, img_rd_en, flt_rd_en, mac_en, mac_clr, out_valid}, 0);
        chk("reset_addr", {img_addr, flt_addr, out_addr}, 0);
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // First pixel, cycle by cycle
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 9) begin
                chk("p0_rd_en", img_rd_en, 1);
                chk("p0_flt_rd_en", flt_rd_en, 1);
                chk("p0_img_addr", img_addr, img_tbl[k-1]);
                chk("p0_flt_addr", flt_addr, k - 1);
            end else begin
                chk("p0_rd_idle", img_rd_en, 0);
            end
            chk("p0_mac_en", mac_en, (k >= 2 && k <= 10) ? 1 : 0);
            chk("p0_mac_clr", mac_clr, (k == 2) ? 1 : 0);
            chk("p0_out_valid", out_valid, (k == 12) ? 1 : 0);
            if (k == 12) chk("p0_out_addr", out_addr, 0);
            chk("p0_busy", busy, 1);
            if (k < 12) @(negedge clk);
        end
        cyc = 12;
        while (!done && cyc < 2400) begin
            @(negedge clk);
            cyc++;
        end
        chk("first_done_cycle", cyc, 2161);
        @(negedge clk);
        chk("first_busy_drop", busy, 0);
        @(negedge clk);

        run_tile(-1, 2161, 1'b0, "full");
        run_tile(7, 2166, 1'b0, "bp");
        run_tile(-1, 2161, 1'b1, "poke");

        // Reset mid-ACCUM of pixel 40
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; hs = 0;
        while (hs < 40 && cyc < 1000) begin
            if (out_valid) hs++;
            @(negedge clk);
            cyc++;
        end
        chk("rst_reached_pix40", hs, 40);
        repeat (2) @(negedge clk);
        chk("rst_mid_accum", img_rd_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_rd", img_rd_en, 0);
        chk("rst_mac", mac_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        run_tile(-1, 2161, 1'b0, "after_rst");

        // Small-tile instance with longer latencies
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        cyc = 1; hs = 0; pix = 0; fin = 0;
        while (!fin && cyc < 200) begin
            if (s_img_rd_en && s_flt_addr == 4'd0) begin
                if (pix < 4) chk("sw_base_addr", s_img_addr, base_tbl[pix]);
                pix++;
            end
            if (cyc == 2) chk("sw_mac_lat", s_mac_en, 0);
            if (cyc == 3) chk("sw_mac_clr", s_mac_clr, 1);
            if (s_out_valid) begin
                chk("sw_out_cycle", cyc, 15 * (hs + 1));
                chk("sw_out_addr", s_out_addr, hs);
                hs++;
            end
            if (s_done) begin
                chk("sw_done_cycle", cyc, 61);
                fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!fin) chk("sw_timeout", 0, 1);
        chk("sw_pixels", hs, 4);
        chk("sw_bases", pix, 4);
        chk("sw_busy_after", s_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_conv_sequencer.md
Name: cnn_conv_sequencer

Overview:
- Control FSM that sequences the CNN convolution datapath over one ROWS x COLS input tile with one K x K filter.
- Stride 1, no padding.
- Issues input-buffer and filter-buffer read addresses, drives MAC clear/enable, and hands each finished output pixel to the output buffer with a valid/ready handshake.
- Sits between the host start/done interface and the buffer/MAC datapath inside cnn_top.

Parameters:
- ROWS, 8, input tile rows.
- COLS, 32, input tile columns.
- K, 3, filter size; K <= ROWS and K <= COLS.
- RD_LAT, 1, buffer read latency in cycles, rd_en to data; >= 1.
- MAC_LAT, 1, cycles from last mac_en to MAC result valid; >= 1.
- Derived: OR = ROWS-K+1 (6), OC = COLS-K+1 (30), IAW = clog2(ROWS*COLS) (8), FAW = clog2(K*K) (4), OAW = clog2(OR*OC) (8).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through DONE inclusive.
- done  out  1  one-cycle pulse, high in the DONE state.
- img_rd_en  out  1  input buffer read strobe.
- img_addr  out  IAW  input buffer address, row-major (row*COLS+col).
- flt_rd_en  out  1  filter buffer read strobe; always equal to img_rd_en.
- flt_addr  out  FAW  filter tap address (kr*K+kc).
- mac_en  out  1  MAC accumulate strobe; img_rd_en delayed by exactly RD_LAT cycles.
- mac_clr  out  1  high with the first mac_en of each pixel; MAC loads the product instead of accumulating.
- out_valid  out  1  MAC result valid for the current pixel.
- out_ready  in  1  output buffer accepts the pixel.
- out_addr  out  OAW  output pixel index (r*OC+c); valid while out_valid.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state -> IDLE; pixel counters r, c and tap counters kr, kc -> 0; RD_LAT delay line cleared.
  - Next cycle all outputs are 0. Applies from any state, mid-run included; no partial done pulse.
- Reset priority: rst has priority over start and all other inputs.
- States: IDLE, ACCUM, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 -> ACCUM, with r=c=kr=kc=0.
  - start=0 -> stay.
- ACCUM (exactly K*K cycles):
  - img_rd_en=flt_rd_en=1; img_addr=(r+kr)*COLS+(c+kc); flt_addr=kr*K+kc.
  - kc increments and wraps at K-1, then kr increments.
  - After tap (K-1,K-1) -> DRAIN, with kr=kc=0.
- DRAIN:
  - Lasts exactly RD_LAT+MAC_LAT cycles (down-counter); no reads issued.
  - mac_en/mac_clr for in-flight reads continue via the delay line.
  - Then -> WRITE.
- WRITE:
  - out_valid=1; out_addr=r*OC+c, held stable until the handshake.
  - out_valid && out_ready at an edge: if r=OR-1 and c=OC-1 -> DONE; otherwise advance c (wrap at OC-1, then r++) and -> ACCUM.
  - out_ready=0: hold; no reads, no MAC strobes.
- DONE: one cycle; done=1, busy=1; -> IDLE.
- start while not IDLE (including DONE): ignored, not queued.
- Timing with out_ready tied 1:
  - Per-pixel period = K*K + RD_LAT + MAC_LAT + 1 (12 at defaults).
  - Full tile = OR*OC*period (2160 at defaults).
  - done asserts 2161 cycles after the start-accept edge.
- Arithmetic: all address math is unsigned and fits its width by construction. Max img_addr = ROWS*COLS-1; max out_addr = OR*OC-1. No wrap.

Test Plan:
- Reset, then start pulse -> first ACCUM:
  - img_addr sequence 0,1,2,32,33,34,64,65,66 and flt_addr 0..8 on consecutive cycles.
  - mac_en the same 9-cycle train, 1 cycle later; mac_clr only with the first.
  - out_valid at cycle 12 with out_addr=0.
- out_ready=1 throughout:
  - exactly 180 out_valid handshakes with out_addr 0..179 in order.
  - last pixel's img_addr runs 189..255.
  - done a single pulse 2161 cycles after the start-accept edge; busy drops the cycle after.
- Backpressure: out_ready=0 for 5 cycles at pixel 7:
  - out_valid and out_addr=7 held constant; img_rd_en=mac_en=0.
  - resumes with pixel 8 one cycle after out_ready=1; total run extends by 5 cycles.
- start pulsed mid-ACCUM and during DONE:
  - no effect; exactly one done pulse; 180 pixels.
- rst=1 for 1 cycle mid-ACCUM of pixel 40:
  - next cycle busy, rd_en, mac_en, out_valid all 0, state IDLE.
  - a new start restarts from out_addr 0 and completes normally.
- Parameter sweep ROWS=4, COLS=4, K=3, RD_LAT=2, MAC_LAT=3:
  - 4 pixels with img base addresses 0,1,4,5.
  - period 15; done 61 cycles after the start-accept edge.
